// File: rtl/zeroriscy_bnn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : zeroriscy_bnn_defines
// Brief    : Opcode/state encodings and per-op helpers for the BNN sequencer.
// Revision : 1.0
// ============================================================================
package zeroriscy_bnn_defines;

    typedef enum logic [2:0] {
        BNN_INI   = 3'd0,
        BNN_ACC   = 3'd1,
        BNN_POOL  = 3'd2,
        BNN_NORM  = 3'd3,
        BNN_ACTIV = 3'd4,
        BNN_ACC8  = 3'd5,
        BNN_SET   = 3'd6,
        BNN_NORM8 = 3'd7
    } bnn_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } bnn_ctrl_state_e;

    function automatic int unsigned bnn_beats(input bnn_op_e op, input int unsigned num_lane);
        case (op)
            BNN_ACC8, BNN_POOL, BNN_NORM, BNN_NORM8: return num_lane;
            default:                                  return 1;
        endcase
    endfunction

    function automatic logic bnn_has_result(input bnn_op_e op);
        return (op == BNN_POOL) || (op == BNN_ACTIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/zeroriscy_bnn_beat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : zeroriscy_bnn_beat_cnt
// Brief    : Lane counter with clear/enable; saturates at the last lane index.
// Revision : 1.0
// ============================================================================
module zeroriscy_bnn_beat_cnt #(
    parameter int unsigned LANE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [LANE_W-1:0] i_last_idx,
    output logic [LANE_W-1:0] o_cnt,
    output logic              o_first,
    output logic              o_last
);

    logic [LANE_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_first = (r_cnt == '0);
    assign o_last  = (r_cnt == i_last_idx);

endmodule
`default_nettype wire

// File: rtl/zeroriscy_bnn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : zeroriscy_bnn_ctrl
// Brief    : Sequences decoded BNN instructions into per-lane datapath beats.
// Revision : 1.0
// ============================================================================
module zeroriscy_bnn_ctrl
    import zeroriscy_bnn_defines::*;
#(
    parameter int unsigned NUM_LANE = 4,
    parameter int unsigned LANE_W   = $clog2(NUM_LANE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bnn_valid_i,
    output logic              bnn_ready_o,
    input  logic [2:0]        bnn_op_i,
    input  logic [31:0]       bnn_opa_i,
    input  logic [31:0]       bnn_opb_i,
    input  logic              bnn_kill_i,
    output logic              bnn_busy_o,
    output logic              bnn_done_o,
    output logic              bnn_we_o,
    output logic [31:0]       bnn_result_o,
    output logic              dp_valid_o,
    input  logic              dp_ready_i,
    output logic [2:0]        dp_op_o,
    output logic [LANE_W-1:0] dp_lane_o,
    output logic              dp_first_o,
    output logic              dp_last_o,
    output logic [31:0]       dp_opa_o,
    output logic [31:0]       dp_opb_o,
    input  logic              dp_rvalid_i,
    input  logic [31:0]       dp_rdata_i
);

    bnn_ctrl_state_e   r_state;
    bnn_ctrl_state_e   w_next;
    bnn_op_e           r_op;
    logic [31:0]       r_opa;
    logic [31:0]       r_opb;
    logic [31:0]       r_rdata;

    logic              w_accept;
    logic              w_issue;
    logic              w_hs;
    logic              w_has_res;
    logic [LANE_W-1:0] w_last_idx;
    logic [LANE_W-1:0] w_cnt;
    logic              w_first;
    logic              w_last;

    assign w_accept   = (r_state == ST_IDLE) && bnn_valid_i && !bnn_kill_i;
    assign w_issue    = (r_state == ST_ISSUE);
    assign w_hs       = w_issue && dp_ready_i;
    assign w_has_res  = bnn_has_result(r_op);
    assign w_last_idx = LANE_W'(bnn_beats(r_op, NUM_LANE) - 1);

    zeroriscy_bnn_beat_cnt #(
        .LANE_W (LANE_W)
    ) u_beat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_accept),
        .i_en       (w_hs),
        .i_last_idx (w_last_idx),
        .o_cnt      (w_cnt),
        .o_first    (w_first),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= BNN_INI;
            r_opa   <= '0;
            r_opb   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op  <= bnn_op_e'(bnn_op_i);
                r_opa <= bnn_opa_i;
                r_opb <= bnn_opb_i;
            end
            if ((r_state == ST_WAIT_R) && dp_rvalid_i) begin
                r_rdata <= dp_rdata_i;
            end
        end
    end

    // Kill wins over every forward transition, including a last-beat handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (bnn_kill_i)            w_next = ST_IDLE;
                else if (w_hs && w_last)   w_next = w_has_res ? ST_WAIT_R : ST_DONE;
            end
            ST_WAIT_R: begin
                if (bnn_kill_i)            w_next = ST_IDLE;
                else if (dp_rvalid_i)      w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign bnn_ready_o  = (r_state == ST_IDLE);
    assign bnn_busy_o   = (r_state != ST_IDLE);
    assign bnn_done_o   = (r_state == ST_DONE) && !bnn_kill_i;
    assign bnn_we_o     = bnn_done_o && w_has_res;
    assign bnn_result_o = bnn_we_o ? r_rdata : 32'h0;

    assign dp_valid_o   = w_issue;
    assign dp_op_o      = r_op;
    assign dp_lane_o    = w_cnt;
    assign dp_first_o   = w_issue && w_first;
    assign dp_last_o    = w_issue && w_last;
    assign dp_opa_o     = r_opa;
    assign dp_opb_o     = r_opb;

endmodule
`default_nettype wire

// File: tb/tb_zeroriscy_bnn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_zeroriscy_bnn_ctrl
// Brief    : Directed bench for the BNN sequencer with beat/result scoreboards.
// Revision : 1.0
// ============================================================================
module tb_zeroriscy_bnn_ctrl;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] lane;
        logic       first;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic        we;
        logic [31:0] res;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bnn_valid_i;
    logic        bnn_ready_o;
    logic [2:0]  bnn_op_i;
    logic [31:0] bnn_opa_i;
    logic [31:0] bnn_opb_i;
    logic        bnn_kill_i;
    logic        bnn_busy_o;
    logic        bnn_done_o;
    logic        bnn_we_o;
    logic [31:0] bnn_result_o;
    logic        dp_valid_o;
    logic        dp_ready_i;
    logic [2:0]  dp_op_o;
    logic [1:0]  dp_lane_o;
    logic        dp_first_o;
    logic        dp_last_o;
    logic [31:0] dp_opa_o;
    logic [31:0] dp_opb_o;
    logic        dp_rvalid_i;
    logic [31:0] dp_rdata_i;

    int total = 0;
    int bad   = 0;

    beat_t exp_beats[$];
    res_t  exp_res[$];

    always #5 clk = ~clk;

    zeroriscy_bnn_ctrl #(
        .NUM_LANE (4),
        .LANE_W   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bnn_valid_i  (bnn_valid_i),
        .bnn_ready_o  (bnn_ready_o),
        .bnn_op_i     (bnn_op_i),
        .bnn_opa_i    (bnn_opa_i),
        .bnn_opb_i    (bnn_opb_i),
        .bnn_kill_i   (bnn_kill_i),
        .bnn_busy_o   (bnn_busy_o),
        .bnn_done_o   (bnn_done_o),
        .bnn_we_o     (bnn_we_o),
        .bnn_result_o (bnn_result_o),
        .dp_valid_o   (dp_valid_o),
        .dp_ready_i   (dp_ready_i),
        .dp_op_o      (dp_op_o),
        .dp_lane_o    (dp_lane_o),
        .dp_first_o   (dp_first_o),
        .dp_last_o    (dp_last_o),
        .dp_opa_o     (dp_opa_o),
        .dp_opb_o     (dp_opb_o),
        .dp_rvalid_i  (dp_rvalid_i),
        .dp_rdata_i   (dp_rdata_i)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: multi-beat ops iterate all four lanes, POOL/ACTIV write rd.
    task automatic push_op(input logic [2:0] op, input logic [31:0] res);
        int   n;
        beat_t b;
        res_t  r;
        n = (op == 3'd2 || op == 3'd3 || op == 3'd5 || op == 3'd7) ? 4 : 1;
        for (int i = 0; i < n; i++) begin
            b.op    = op;
            b.lane  = 2'(i);
            b.first = (i == 0);
            b.last  = (i == n - 1);
            exp_beats.push_back(b);
        end
        r.we  = (op == 3'd2 || op == 3'd4);
        r.res = r.we ? res : 32'h0;
        exp_res.push_back(r);
    endtask

    always @(negedge clk) begin
        beat_t b_obs;
        beat_t b_exp;
        res_t  r_exp;
        if (dp_valid_o && dp_ready_i) begin
            b_obs = {dp_op_o, dp_lane_o, dp_first_o, dp_last_o};
            if (exp_beats.size() != 0) begin
                b_exp = exp_beats.pop_front();
                chk32("sb_beat", 32'(b_obs), 32'(b_exp));
            end else begin
                chk32("sb_beat_unexpected", 32'(b_obs), 32'h100);
            end
        end
        if (bnn_done_o) begin
            if (exp_res.size() != 0) begin
                r_exp = exp_res.pop_front();
                chk1("sb_we", bnn_we_o, r_exp.we);
                chk32("sb_result", bnn_result_o, r_exp.res);
            end else begin
                chk32("sb_done_unexpected", bnn_result_o, 32'hBAD0_0BAD);
                chk1("sb_done_unexpected", bnn_done_o, 1'b0);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        bnn_valid_i = 1'b0;
        bnn_op_i    = 3'd0;
        bnn_opa_i   = 32'h0;
        bnn_opb_i   = 32'h0;
        bnn_kill_i  = 1'b0;
        dp_ready_i  = 1'b1;
        dp_rvalid_i = 1'b0;
        dp_rdata_i  = 32'h0;
        tick();
        tick();

        chk1("rst_ready", bnn_ready_o, 1'b1);
        chk1("rst_busy", bnn_busy_o, 1'b0);
        chk1("rst_done", bnn_done_o, 1'b0);
        chk1("rst_we", bnn_we_o, 1'b0);
        chk32("rst_result", bnn_result_o, 32'h0);
        chk1("rst_dp_valid", dp_valid_o, 1'b0);
        chk1("rst_dp_first", dp_first_o, 1'b0);
        chk1("rst_dp_last", dp_last_o, 1'b0);
        chk32("rst_dp_lane", 32'(dp_lane_o), 32'h0);
        chk32("rst_dp_op", 32'(dp_op_o), 32'h0);
        chk32("rst_dp_opa", dp_opa_o, 32'h0);
        chk32("rst_dp_opb", dp_opb_o, 32'h0);
        rst_n = 1'b1;

        // kill while idle must block acceptance
        bnn_valid_i = 1'b1;
        bnn_op_i    = 3'd6;
        bnn_kill_i  = 1'b1;
        tick();
        chk1("idle_kill_ready", bnn_ready_o, 1'b1);
        chk1("idle_kill_busy", bnn_busy_o, 1'b0);
        bnn_valid_i = 1'b0;
        bnn_kill_i  = 1'b0;

        // ACC8: four back-to-back lanes, no writeback
        bnn_valid_i = 1'b1;
        bnn_op_i    = 3'd5;
        bnn_opa_i   = 32'hA5A5_0F0F;
        bnn_opb_i   = 32'h0000_1234;
        push_op(3'd5, 32'h0);
        tick();
        bnn_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("acc8_valid", dp_valid_o, 1'b1);
            chk32("acc8_lane", 32'(dp_lane_o), i);
            chk1("acc8_first", dp_first_o, i == 0);
            chk1("acc8_last", dp_last_o, i == 3);
            chk32("acc8_opa", dp_opa_o, 32'hA5A5_0F0F);
            chk1("acc8_ready", bnn_ready_o, 1'b0);
            tick();
        end
        chk1("acc8_done", bnn_done_o, 1'b1);
        chk1("acc8_we", bnn_we_o, 1'b0);
        chk1("acc8_dp_valid_off", dp_valid_o, 1'b0);
        tick();
        chk1("acc8_ready_back", bnn_ready_o, 1'b1);
        chk1("acc8_done_pulse", bnn_done_o, 1'b0);

        // ACC held under backpressure for three cycles
        bnn_valid_i = 1'b1;
        bnn_op_i    = 3'd1;
        bnn_opa_i   = 32'h1111_1111;
        bnn_opb_i   = 32'h2222_2222;
        dp_ready_i  = 1'b0;
        push_op(3'd1, 32'h0);
        tick();
        bnn_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("hold_valid", dp_valid_o, 1'b1);
            chk32("hold_lane", 32'(dp_lane_o), 32'h0);
            chk1("hold_first", dp_first_o, 1'b1);
            chk1("hold_last", dp_last_o, 1'b1);
            chk32("hold_op", 32'(dp_op_o), 32'h1);
            chk32("hold_opa", dp_opa_o, 32'h1111_1111);
            chk32("hold_opb", dp_opb_o, 32'h2222_2222);
            chk1("hold_no_done", bnn_done_o, 1'b0);
            if (i == 3) dp_ready_i = 1'b1;
            tick();
        end
        chk1("hold_done", bnn_done_o, 1'b1);
        tick();
        chk1("hold_ready_back", bnn_ready_o, 1'b1);

        // ACTIV with stray rvalid outside WAIT_R, then real read data
        bnn_valid_i = 1'b1;
        bnn_op_i    = 3'd4;
        bnn_opa_i   = 32'hCAFE_0001;
        dp_rvalid_i = 1'b1;
        dp_rdata_i  = 32'hDEAD_BEEF;
        push_op(3'd4, 32'h0000_0013);
        tick();
        bnn_valid_i = 1'b0;
        chk1("activ_beat", dp_valid_o, 1'b1);
        chk1("activ_last", dp_last_o, 1'b1);
        tick();
        dp_rvalid_i = 1'b0;
        dp_rdata_i  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk1("activ_wait_valid", dp_valid_o, 1'b0);
            chk1("activ_wait_busy", bnn_busy_o, 1'b1);
            chk1("activ_wait_done", bnn_done_o, 1'b0);
            tick();
        end
        dp_rvalid_i = 1'b1;
        dp_rdata_i  = 32'h0000_0013;
        tick();
        dp_rvalid_i = 1'b0;
        dp_rdata_i  = 32'h0;
        chk1("activ_done", bnn_done_o, 1'b1);
        chk1("activ_we", bnn_we_o, 1'b1);
        chk32("activ_result", bnn_result_o, 32'h0000_0013);
        tick();
        chk1("activ_ready_back", bnn_ready_o, 1'b1);
        chk32("activ_result_cleared", bnn_result_o, 32'h0);

        // POOL killed during lane 2, then SET accepted immediately
        bnn_valid_i = 1'b1;
        bnn_op_i    = 3'd2;
        bnn_opa_i   = 32'h0BAD_F00D;
        push_op(3'd2, 32'h0);
        tick();
        bnn_valid_i = 1'b0;
        chk32("pool_lane0", 32'(dp_lane_o), 32'h0);
        tick();
        chk32("pool_lane1", 32'(dp_lane_o), 32'h1);
        tick();
        chk32("pool_lane2", 32'(dp_lane_o), 32'h2);
        bnn_kill_i = 1'b1;
        tick();
        bnn_kill_i = 1'b0;
        chk1("kill_busy", bnn_busy_o, 1'b0);
        chk1("kill_ready", bnn_ready_o, 1'b1);
        chk1("kill_dp_valid", dp_valid_o, 1'b0);
        chk1("kill_done", bnn_done_o, 1'b0);
        chk32("kill_beats_left", exp_beats.size(), 32'd1);
        chk32("kill_res_left", exp_res.size(), 32'd1);
        exp_beats.delete();
        exp_res.delete();
        bnn_valid_i = 1'b1;
        bnn_op_i    = 3'd6;
        push_op(3'd6, 32'h0);
        tick();
        bnn_valid_i = 1'b0;
        chk1("set_busy", bnn_busy_o, 1'b1);
        chk1("set_dp_valid", dp_valid_o, 1'b1);
        chk32("set_dp_op", 32'(dp_op_o), 32'h6);
        tick();
        chk1("set_done", bnn_done_o, 1'b1);
        chk1("set_we", bnn_we_o, 1'b0);
        tick();

        // reset while waiting for read data; late rvalid ignored
        bnn_valid_i = 1'b1;
        bnn_op_i    = 3'd4;
        bnn_opa_i   = 32'h5555_AAAA;
        bnn_opb_i   = 32'h3333_CCCC;
        push_op(3'd4, 32'h0);
        tick();
        bnn_valid_i = 1'b0;
        tick();
        chk1("wr_busy", bnn_busy_o, 1'b1);
        chk1("wr_dp_valid", dp_valid_o, 1'b0);
        rst_n = 1'b0;
        tick();
        chk1("wr_rst_ready", bnn_ready_o, 1'b1);
        chk1("wr_rst_busy", bnn_busy_o, 1'b0);
        chk1("wr_rst_done", bnn_done_o, 1'b0);
        chk1("wr_rst_we", bnn_we_o, 1'b0);
        chk32("wr_rst_result", bnn_result_o, 32'h0);
        chk32("wr_rst_dp_op", 32'(dp_op_o), 32'h0);
        chk32("wr_rst_dp_opa", dp_opa_o, 32'h0);
        chk32("wr_rst_dp_opb", dp_opb_o, 32'h0);
        rst_n       = 1'b1;
        dp_rvalid_i = 1'b1;
        dp_rdata_i  = 32'h0000_0077;
        tick();
        dp_rvalid_i = 1'b0;
        dp_rdata_i  = 32'h0;
        chk1("late_rvalid_done", bnn_done_o, 1'b0);
        chk1("late_rvalid_busy", bnn_busy_o, 1'b0);
        tick();
        chk1("late_rvalid_done2", bnn_done_o, 1'b0);
        chk32("wr_res_left", exp_res.size(), 32'd1);
        exp_res.delete();

        // INI then NORM8 with valid held high
        bnn_valid_i = 1'b1;
        bnn_op_i    = 3'd0;
        bnn_opa_i   = 32'h0000_00FF;
        push_op(3'd0, 32'h0);
        tick();
        bnn_op_i = 3'd7;
        push_op(3'd7, 32'h0);
        chk1("b2b_c1_ready", bnn_ready_o, 1'b0);
        tick();
        chk1("b2b_c2_ready", bnn_ready_o, 1'b0);
        chk1("b2b_c2_done", bnn_done_o, 1'b1);
        tick();
        chk1("b2b_c3_ready", bnn_ready_o, 1'b1);
        tick();
        bnn_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("norm8_valid", dp_valid_o, 1'b1);
            chk32("norm8_op", 32'(dp_op_o), 32'h7);
            chk32("norm8_lane", 32'(dp_lane_o), i);
            chk1("norm8_last", dp_last_o, i == 3);
            tick();
        end
        chk1("norm8_done", bnn_done_o, 1'b1);
        tick();
        chk1("norm8_ready_back", bnn_ready_o, 1'b1);

        chk32("sb_beats_drained", exp_beats.size(), 32'd0);
        chk32("sb_res_drained", exp_res.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
